// File: rtl/ra_seq.sv
// ra_seq: micro-sequencer for the register array (R0-R3 plus flag register).
// Takes one register-transfer command at a time from the instruction decoder
// and drives the array's load (i_*) and output-enable (e_*) strobes cycle by
// cycle. At most one source drives the shared data bus in any cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      command strobe, sampled only in IDLE
//   op[2:0]    000 NOP, 001 MOV, 010 LDI, 011 MUL, 100 DIV, 101 FRD, 11x illegal
//   rs[1:0]    source register (MOV)
//   rd[1:0]    destination register (MOV, LDI)
//   alu_done   ALU result and flags valid
//   i_r[3:0]   one-hot load strobes R0..R3
//   e_r[3:0]   one-hot output enables R0..R3
//   i_f, e_f   flag register load / output enable
//   imul, idiv R1 load-from-ALU strobes
//   ext_oe     external source drives the bus (LDI)
//   alu_go     single-cycle ALU start pulse
//   busy       command in progress
//   done       single-cycle completion pulse
//   err        sticky error flag, cleared by the next accepted start
//
// State      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for start
// S_DRIVE    | source enable on, bus settling (MOV/LDI)
// S_LATCH    | source enable held, destination load strobe
// S_WAIT_ALU | waiting for alu_done, timeout counter running
// S_WB       | R1 load from ALU (imul/idiv)
// S_FLAG     | flag register load
// S_FRD      | flag register drives the bus
// S_DONE     | done pulse, back to IDLE
module ra_seq #(
    parameter int ALU_TIMEOUT = 16,
    parameter int TW          = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [1:0] rs,
    input  logic [1:0] rd,
    input  logic       alu_done,
    output logic [3:0] i_r,
    output logic [3:0] e_r,
    output logic       i_f,
    output logic       e_f,
    output logic       imul,
    output logic       idiv,
    output logic       ext_oe,
    output logic       alu_go,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DRIVE    = 3'd1;
    localparam logic [2:0] S_LATCH    = 3'd2;
    localparam logic [2:0] S_WAIT_ALU = 3'd3;
    localparam logic [2:0] S_WB       = 3'd4;
    localparam logic [2:0] S_FLAG     = 3'd5;
    localparam logic [2:0] S_FRD      = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_LDI = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;
    localparam logic [2:0] OP_FRD = 3'd5;

    localparam logic [TW-1:0] CNT_LAST = TW'(ALU_TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [1:0]    rs_q, rs_d;
    logic [1:0]    rd_q, rd_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    rs_d  = rs;
                    rd_d  = rd;
                    err_d = 1'b0;
                    cnt_d = '0;
                    case (op)
                        OP_NOP:         state_d = S_DONE;
                        OP_MOV, OP_LDI: state_d = S_DRIVE;
                        OP_MUL, OP_DIV: state_d = S_WAIT_ALU;
                        OP_FRD:         state_d = S_FRD;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            // A self-move has nothing to capture: skip the load cycle.
            S_DRIVE:  state_d = (op_q == OP_MOV && rs_q == rd_q) ? S_DONE : S_LATCH;
            S_LATCH:  state_d = S_DONE;
            S_WAIT_ALU: begin
                // alu_done is tested first so a completion in the last
                // allowed cycle still writes back.
                if (alu_done) begin
                    state_d = S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WB:     state_d = S_FLAG;
            S_FLAG:   state_d = S_DONE;
            S_FRD:    state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            rs_q    <= 2'd0;
            rd_q    <= 2'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Moore decode: every strobe comes from state_q and the latched fields,
    // so an asynchronous reset to IDLE clears them all at once.
    always_comb begin
        i_r    = 4'b0000;
        e_r    = 4'b0000;
        i_f    = 1'b0;
        e_f    = 1'b0;
        imul   = 1'b0;
        idiv   = 1'b0;
        ext_oe = 1'b0;
        alu_go = 1'b0;
        done   = 1'b0;
        case (state_q)
            S_DRIVE, S_LATCH: begin
                if (op_q == OP_MOV) begin
                    e_r = 4'b0001 << rs_q;
                end else begin
                    ext_oe = 1'b1;
                end
                if (state_q == S_LATCH) begin
                    i_r = 4'b0001 << rd_q;
                end
            end
            S_WAIT_ALU: alu_go = (cnt_q == '0);
            S_WB: begin
                imul = (op_q == OP_MUL);
                idiv = (op_q == OP_DIV);
            end
            S_FLAG:  i_f  = 1'b1;
            S_FRD:   e_f  = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_ra_seq.sv
module tb_ra_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [1:0] rs;
    logic [1:0] rd;
    logic       alu_done;
    logic [3:0] i_r, e_r;
    logic       i_f, e_f, imul, idiv, ext_oe, alu_go, busy, done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ra_seq #(.ALU_TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rd(rd),
        .alu_done(alu_done), .i_r(i_r), .e_r(e_r), .i_f(i_f), .e_f(e_f),
        .imul(imul), .idiv(idiv), .ext_oe(ext_oe), .alu_go(alu_go),
        .busy(busy), .done(done), .err(err)
    );

    // Packed view of all outputs: {i_r, e_r, i_f, e_f, imul, idiv, ext_oe, alu_go, busy, done, err}
    logic [16:0] obs;
    assign obs = {i_r, e_r, i_f, e_f, imul, idiv, ext_oe, alu_go, busy, done, err};

    localparam logic [16:0] K_ERR  = 17'h00001;
    localparam logic [16:0] K_DONE = 17'h00002;
    localparam logic [16:0] K_BUSY = 17'h00004;
    localparam logic [16:0] K_GO   = 17'h00008;
    localparam logic [16:0] K_EXT  = 17'h00010;
    localparam logic [16:0] K_IDIV = 17'h00020;
    localparam logic [16:0] K_IMUL = 17'h00040;
    localparam logic [16:0] K_EF   = 17'h00080;
    localparam logic [16:0] K_IF   = 17'h00100;
    localparam logic [16:0] K_STAT = K_BUSY | K_DONE | K_ERR;

    function automatic logic [16:0] fe(input logic [3:0] v);
        return {4'b0000, v, 9'b0};
    endfunction

    function automatic logic [16:0] fi(input logic [3:0] v);
        return {v, 13'b0};
    endfunction

    // Bus exclusivity, every cycle outside reset
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if (($countones(e_r) + int'(e_f) + int'(ext_oe)) > 1 || $countones(i_r) > 1 ||
                (imul && idiv) || (i_r[1] && (imul || idiv))) begin
                errors++;
                $display("FAIL bus_exclusive: i_r=%b e_r=%b e_f=%b ext_oe=%b imul=%b idiv=%b (required at most one driver/loader)",
                         i_r, e_r, e_f, ext_oe, imul, idiv);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a start for one edge; returns positioned in cycle 1.
    task automatic start_cmd(input logic [2:0] o, input logic [1:0] s, input logic [1:0] d);
        start = 1'b1; op = o; rs = s; rd = d;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] exp;
        #12;
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL reset_state: got %h required %h", obs, exp); end
        @(negedge clk) rst = 1'b1;
        step();
        checks++; if (obs !== exp) begin errors++; $display("FAIL idle_after_release: got %h required %h", obs, exp); end
        start_cmd(3'b111, 2'd0, 2'd0);
        exp = K_BUSY | K_DONE | K_ERR;
        checks++; if (obs !== exp) begin errors++; $display("FAIL pre_illegal: got %h required %h", obs, exp); end
        step();
        exp = K_ERR;
        checks++; if (obs !== exp) begin errors++; $display("FAIL pre_err_sticky: got %h required %h", obs, exp); end
        start_cmd(3'b001, 2'd1, 2'd2);
        exp = K_BUSY | fe(4'b0010);
        checks++; if (obs !== exp) begin errors++; $display("FAIL rst_mov_c1: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | fe(4'b0010) | fi(4'b0100);
        checks++; if (obs !== exp) begin errors++; $display("FAIL rst_mov_c2: got %h required %h", obs, exp); end
        #2 rst = 1'b0;
        #1;
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL reset_mid_latch: got %h required %h", obs, exp); end
        @(negedge clk) rst = 1'b1;
        step();
        checks++; if (obs !== exp) begin errors++; $display("FAIL idle_after_reset: got %h required %h", obs, exp); end
        start_cmd(3'b001, 2'd0, 2'd3);
        exp = K_BUSY | fe(4'b0001);
        checks++; if (obs !== exp) begin errors++; $display("FAIL post_rst_mov_c1: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | fe(4'b0001) | fi(4'b1000);
        checks++; if (obs !== exp) begin errors++; $display("FAIL post_rst_mov_c2: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_DONE;
        checks++; if (obs !== exp) begin errors++; $display("FAIL post_rst_mov_c3: got %h required %h", obs, exp); end
        step();
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL post_rst_idle: got %h required %h", obs, exp); end
    endtask

    task automatic test_mov();
        logic [16:0] exp;
        start_cmd(3'b001, 2'd2, 2'd0);
        exp = K_BUSY | fe(4'b0100);
        checks++; if (obs !== exp) begin errors++; $display("FAIL mov_c1: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | fe(4'b0100) | fi(4'b0001);
        checks++; if (obs !== exp) begin errors++; $display("FAIL mov_c2: got %h required %h", obs, exp); end
        start = 1'b1; op = 3'b010; rd = 2'd1;
        step();
        start = 1'b0;
        exp = K_BUSY | K_DONE;
        checks++; if (obs !== exp) begin errors++; $display("FAIL mov_c3: got %h required %h", obs, exp); end
        step();
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL mov_ignored_start: got %h required %h", obs, exp); end
    endtask

    task automatic test_mov_same();
        logic [16:0] exp;
        start_cmd(3'b001, 2'd3, 2'd3);
        exp = K_BUSY | fe(4'b1000);
        checks++; if (obs !== exp) begin errors++; $display("FAIL mov_same_c1: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_DONE;
        checks++; if (obs !== exp) begin errors++; $display("FAIL mov_same_c2: got %h required %h", obs, exp); end
        step();
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL mov_same_idle: got %h required %h", obs, exp); end
    endtask

    task automatic test_ldi();
        logic [16:0] exp;
        start_cmd(3'b010, 2'd0, 2'd1);
        exp = K_BUSY | K_EXT;
        checks++; if (obs !== exp) begin errors++; $display("FAIL ldi_c1: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_EXT | fi(4'b0010);
        checks++; if (obs !== exp) begin errors++; $display("FAIL ldi_c2: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_DONE;
        checks++; if (obs !== exp) begin errors++; $display("FAIL ldi_c3: got %h required %h", obs, exp); end
        step();
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL ldi_idle: got %h required %h", obs, exp); end
    endtask

    task automatic test_mul();
        logic [16:0] exp;
        start_cmd(3'b011, 2'd0, 2'd0);
        for (int c = 1; c <= 4; c++) begin
            exp = K_BUSY | ((c == 1) ? K_GO : 17'h0);
            checks++; if (obs !== exp) begin errors++; $display("FAIL mul_wait_c%0d: got %h required %h", c, obs, exp); end
            if (c == 4) alu_done = 1'b1;
            step();
            alu_done = 1'b0;
        end
        exp = K_BUSY | K_IMUL;
        checks++; if (obs !== exp) begin errors++; $display("FAIL mul_c5_wb: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_IF;
        checks++; if (obs !== exp) begin errors++; $display("FAIL mul_c6_flag: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_DONE;
        checks++; if (obs !== exp) begin errors++; $display("FAIL mul_c7_done: got %h required %h", obs, exp); end
        step();
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL mul_idle: got %h required %h", obs, exp); end
    endtask

    task automatic test_div_timeout();
        logic [16:0] exp;
        start_cmd(3'b100, 2'd0, 2'd0);
        for (int c = 1; c <= 16; c++) begin
            exp = K_BUSY | ((c == 1) ? K_GO : 17'h0);
            checks++; if (obs !== exp) begin errors++; $display("FAIL div_to_c%0d: got %h required %h", c, obs, exp); end
            step();
        end
        exp = K_BUSY | K_DONE | K_ERR;
        checks++; if (obs !== exp) begin errors++; $display("FAIL div_to_c17: got %h required %h", obs, exp); end
        step();
        exp = K_ERR;
        checks++; if (obs !== exp) begin errors++; $display("FAIL div_to_err_sticky: got %h required %h", obs, exp); end
        step();
        checks++; if (obs !== exp) begin errors++; $display("FAIL div_to_err_hold: got %h required %h", obs, exp); end
        // FRD clears err on acceptance
        start_cmd(3'b101, 2'd0, 2'd0);
        exp = K_BUSY | K_EF;
        checks++; if (obs !== exp) begin errors++; $display("FAIL frd_c1: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_DONE;
        checks++; if (obs !== exp) begin errors++; $display("FAIL frd_c2: got %h required %h", obs, exp); end
        step();
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL frd_idle: got %h required %h", obs, exp); end
    endtask

    task automatic test_alu_priority();
        logic [16:0] exp;
        start_cmd(3'b100, 2'd0, 2'd0);
        for (int c = 1; c <= 16; c++) begin
            exp = K_BUSY | ((c == 1) ? K_GO : 17'h0);
            checks++; if (obs !== exp) begin errors++; $display("FAIL prio_c%0d: got %h required %h", c, obs, exp); end
            if (c == 16) alu_done = 1'b1;
            step();
            alu_done = 1'b0;
        end
        exp = K_BUSY | K_IDIV;
        checks++; if (obs !== exp) begin errors++; $display("FAIL prio_c17_wb: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_IF;
        checks++; if (obs !== exp) begin errors++; $display("FAIL prio_c18_flag: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_DONE;
        checks++; if (obs !== exp) begin errors++; $display("FAIL prio_c19_done: got %h required %h", obs, exp); end
        step();
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL prio_idle: got %h required %h", obs, exp); end
    endtask

    task automatic test_illegal();
        logic [16:0] exp;
        start_cmd(3'b110, 2'd1, 2'd2);
        exp = K_BUSY | K_DONE | K_ERR;
        checks++; if (obs !== exp) begin errors++; $display("FAIL illegal6_c1: got %h required %h", obs, exp); end
        step();
        exp = K_ERR;
        checks++; if (obs !== exp) begin errors++; $display("FAIL illegal6_idle: got %h required %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        start_cmd(3'b000, 2'd0, 2'd0);
        exp = K_BUSY | K_DONE;
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_nop_c1: got %h required %h", obs, exp); end
        step();
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_gap: got %h required %h", obs, exp); end
        start_cmd(3'b010, 2'd0, 2'd3);
        exp = K_BUSY | K_EXT;
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_ldi_c1: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_EXT | fi(4'b1000);
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_ldi_c2: got %h required %h", obs, exp); end
        step();
        exp = K_BUSY | K_DONE;
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_ldi_c3: got %h required %h", obs, exp); end
        step();
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_idle: got %h required %h", obs, exp); end
    endtask

    task automatic test_random();
        logic [16:0] exp;
        logic [2:0]  o;
        logic [1:0]  s, d;
        int          k, lat;
        logic        e, is_alu;
        for (int n = 0; n < 1500; n++) begin
            o = 3'($urandom_range(0, 7));
            s = 2'($urandom_range(0, 3));
            d = 2'($urandom_range(0, 3));
            k = $urandom_range(1, 20);
            is_alu = (o == 3'd3 || o == 3'd4);
            e = 1'b0;
            case (o)
                3'd0:       lat = 1;
                3'd1:       lat = (s == d) ? 2 : 3;
                3'd2:       lat = 3;
                3'd3, 3'd4: begin
                    if (k <= 16) lat = k + 3;
                    else begin lat = 17; e = 1'b1; end
                end
                3'd5:       lat = 2;
                default:    begin lat = 1; e = 1'b1; end
            endcase
            start_cmd(o, s, d);
            for (int c = 1; c <= lat; c++) begin
                exp = K_BUSY | ((c == lat) ? (K_DONE | (e ? K_ERR : 17'h0)) : 17'h0);
                checks++; if ((obs & K_STAT) !== exp) begin errors++; $display("FAIL rnd_cmd%0d_op%0d_c%0d: got %h required %h", n, o, c, obs & K_STAT, exp); end
                alu_done = is_alu ? (c == k) : 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
                op = 3'($urandom_range(0, 7));
                step();
                start = 1'b0;
                alu_done = 1'b0;
            end
            exp = e ? K_ERR : 17'h0;
            checks++; if (obs !== exp) begin errors++; $display("FAIL rnd_cmd%0d_idle: got %h required %h", n, obs, exp); end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 3'd0; rs = 2'd0; rd = 2'd0; alu_done = 1'b0;
        test_reset();
        test_mov();
        test_mov_same();
        test_ldi();
        test_mul();
        test_div_timeout();
        test_alu_priority();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
